// File: rtl/uart_fifo.sv
// 8N1 UART with 16-deep TX and RX byte FIFOs behind a req/ack host port.
// Define UART_FIFO_RX_SYNC_EN to pass rx through a 2-flop synchroniser.

module uart_fifo_buf #(
   parameter int AW = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [7:0]    mem_q [1 << AW];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == FULL_CNT);
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end
endmodule

module uart_fifo #(
   parameter int CLOCK_DIV          = 8,
   parameter int CLOCK_COUNTER_BITS = 4,
   parameter int FIFO_DEPTH_BITS    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       tx,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       req,
   input  logic       nwr,
   output logic       ack,
   output logic       full,
   output logic       empty
);
   localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
   localparam logic [CLOCK_COUNTER_BITS-1:0] CNT_HALF = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   logic       ack_q;
   logic [7:0] data_out_q;
   logic       accept;
   logic       txf_push, txf_pop, txf_full, txf_empty;
   logic [7:0] txf_rdata;
   logic       rxf_push, rxf_pop, rxf_full, rxf_empty;
   logic [7:0] rxf_rdata;

   // one transfer per req assertion: a new request is only taken once ack has dropped
   assign accept   = req && !ack_q;
   assign txf_push = accept && !nwr && !txf_full;
   assign rxf_pop  = accept && nwr;

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         if (accept)    ack_q <= 1'b1;
         else if (!req) ack_q <= 1'b0;
         if (rxf_pop && !rxf_empty) data_out_q <= rxf_rdata;
      end
   end

   uart_fifo_buf #(.AW(FIFO_DEPTH_BITS)) u_txf (
      .clk(clk), .reset(reset), .push(txf_push), .pop(txf_pop), .wdata(data_in),
      .rdata(txf_rdata), .full(txf_full), .empty(txf_empty)
   );

   state_e                        tx_state_q;
   logic [CLOCK_COUNTER_BITS-1:0] tx_cnt_q;
   logic [2:0]                    tx_bit_q;
   logic [7:0]                    tx_shift_q;
   logic                          tx_q;

   // a pending byte is taken from IDLE or at the very end of a stop bit (no idle gap)
   assign txf_pop = !txf_empty &&
                    ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_cnt_q == CNT_LAST));

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_cnt_q <= (tx_state_q == S_IDLE || tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + 1'b1;
         case (tx_state_q)
            S_IDLE: if (txf_pop) begin
               tx_state_q <= S_START;
               tx_shift_q <= txf_rdata;
               tx_q       <= 1'b0;
            end
            S_START: if (tx_cnt_q == CNT_LAST) begin
               tx_state_q <= S_DATA;
               tx_bit_q   <= '0;
               tx_q       <= tx_shift_q[0];
            end
            S_DATA: if (tx_cnt_q == CNT_LAST) begin
               if (tx_bit_q == 3'd7) begin
                  tx_state_q <= S_STOP;
                  tx_q       <= 1'b1;
               end else begin
                  tx_bit_q   <= tx_bit_q + 1'b1;
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_q       <= tx_shift_q[1];
               end
            end
            S_STOP: if (tx_cnt_q == CNT_LAST) begin
               if (txf_pop) begin
                  tx_state_q <= S_START;
                  tx_shift_q <= txf_rdata;
                  tx_q       <= 1'b0;
               end else begin
                  tx_state_q <= S_IDLE;
               end
            end
            default: tx_state_q <= S_IDLE;
         endcase
      end
   end

   logic rx_s;
`ifdef UART_FIFO_RX_SYNC_EN
   logic [1:0] rx_sync_q;
   always_ff @(posedge clk) begin
      if (reset) rx_sync_q <= 2'b11;
      else       rx_sync_q <= {rx_sync_q[0], rx};
   end
   assign rx_s = rx_sync_q[1];
`else
   assign rx_s = rx;
`endif

   state_e                        rx_state_q;
   logic [CLOCK_COUNTER_BITS-1:0] rx_cnt_q;
   logic [2:0]                    rx_bit_q;
   logic [7:0]                    rx_shift_q;
   logic                          rx_prev_q;

   assign rxf_push = (rx_state_q == S_STOP) && (rx_cnt_q == CNT_LAST) && rx_s && !rxf_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_prev_q  <= 1'b1;
      end else begin
         rx_prev_q <= rx_s;
         rx_cnt_q  <= (rx_state_q == S_IDLE || rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + 1'b1;
         case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s) rx_state_q <= S_START;
            // half a bit in: realign the counter so later samples land mid-bit
            S_START: if (rx_cnt_q == CNT_HALF) begin
               if (rx_s) begin
                  rx_state_q <= S_IDLE;
               end else begin
                  rx_state_q <= S_DATA;
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
               end
            end
            S_DATA: if (rx_cnt_q == CNT_LAST) begin
               rx_shift_q <= {rx_s, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
               else                  rx_bit_q   <= rx_bit_q + 1'b1;
            end
            S_STOP: if (rx_cnt_q == CNT_LAST) rx_state_q <= S_IDLE;
            default: rx_state_q <= S_IDLE;
         endcase
      end
   end

   uart_fifo_buf #(.AW(FIFO_DEPTH_BITS)) u_rxf (
      .clk(clk), .reset(reset), .push(rxf_push), .pop(rxf_pop), .wdata(rx_shift_q),
      .rdata(rxf_rdata), .full(rxf_full), .empty(rxf_empty)
   );

   assign tx       = tx_q;
   assign ack      = ack_q;
   assign data_out = data_out_q;
   assign full     = txf_full;
   assign empty    = rxf_empty;
endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: stimulus queues expected read data and
// expected transmitted bytes; two monitors pop and compare independently.
module tb_uart_fifo;
   localparam int DIV = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx, tx, ack, full, empty;
   logic       req = 1'b0;
   logic       nwr = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       loop_en = 1'b0;
   logic       rx_drv = 1'b1;
   logic       tx_last = 1'b1;
   logic       ack_last = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0] rd_exp[$];
   logic [7:0] tx_exp[$];

   assign rx = loop_en ? tx : rx_drv;
   always #5 clk = ~clk;

   uart_fifo #(.CLOCK_DIV(DIV), .CLOCK_COUNTER_BITS(4), .FIFO_DEPTH_BITS(4)) dut (
      .clk(clk), .reset(reset), .rx(rx), .tx(tx), .data_in(data_in), .data_out(data_out),
      .req(req), .nwr(nwr), .ack(ack), .full(full), .empty(empty)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // one bus transfer; optionally keep req high for `hold` cycles after ack
   task automatic xfer(input logic rd, input logic [7:0] d, input int hold);
      int n;
      n = 0;
      @(negedge clk);
      req = 1'b1; nwr = rd; data_in = d;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 20);
      check("ack_rise", 32'(ack), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("ack_held", 32'(ack), 32'd1);
      end
      req = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         repeat (DIV) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic wait_neg(input int n, inout logic ab);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (reset) ab = 1'b1;
      end
   endtask

   // read-data monitor: every read ack must present the next queued byte
   initial begin : rd_monitor
      forever begin
         @(negedge clk);
         if (ack && !ack_last && nwr) begin
            if (rd_exp.size() == 0) fail("rd_unexpected_ack");
            else check("data_out", 32'(data_out), 32'(rd_exp.pop_front()));
         end
         ack_last = ack;
      end
   end

   // serial decoder on tx, sampling mid-bit; a reset mid-frame abandons the frame
   initial begin : tx_monitor
      logic       ab;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!reset && tx_last && !tx) begin
            ab = 1'b0;
            b  = '0;
            wait_neg(DIV / 2 - 1, ab);
            if (!ab) check("tx_start_bit", 32'(tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
               if (!ab) wait_neg(DIV, ab);
               b[i] = tx;
            end
            if (!ab) wait_neg(DIV, ab);
            if (!ab) begin
               check("tx_stop_bit", 32'(tx), 32'd1);
               if (tx_exp.size() == 0) fail("tx_unexpected_frame");
               else check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
            end
         end
         tx_last = tx;
      end
   end

   initial begin : stim
      int n;
      logic [9:0] pat;

      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      reset = 1'b0;

      // loopback: two bytes out and back in
      loop_en = 1'b1;
      tx_exp.push_back(8'h5A); xfer(1'b0, 8'h5A, 0);
      tx_exp.push_back(8'hA5); xfer(1'b0, 8'hA5, 0);
      n = 0;
      while (empty && n < 150) begin
         @(negedge clk);
         n++;
      end
      check("t1_empty_after_frame", 32'(empty), 32'd0);
      check("t1_rx_latency_window", 32'(n >= 70 && n <= 82), 32'd1);
      repeat (100) @(negedge clk);
      rd_exp.push_back(8'h5A); xfer(1'b1, 8'h00, 0);
      rd_exp.push_back(8'hA5); xfer(1'b1, 8'h00, 0);
      check("t1_empty_drained", 32'(empty), 32'd1);

      // read from empty RX FIFO, with req held past ack
      rd_exp.push_back(8'hA5); xfer(1'b1, 8'h00, 3);
      @(negedge clk);
      check("t3_ack_drop", 32'(ack), 32'd0);
      check("t3_empty", 32'(empty), 32'd1);

      // cycle-exact tx waveform for 0x5A
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      pat = {1'b1, 8'h5A, 1'b0};
      tx_exp.push_back(8'h5A); xfer(1'b0, 8'h5A, 0);
      for (int k = 0; k < 10 * DIV; k++) begin
         @(negedge clk);
         check("t2_tx_wave", 32'(tx), 32'(pat[k / DIV]));
      end
      @(negedge clk);
      check("t2_tx_idle", 32'(tx), 32'd1);

      // fill TX FIFO: byte 0 goes straight to the shifter, 16 more fill it, the 18th drops
      for (int i = 0; i < 18; i++) begin
         if (i < 17) tx_exp.push_back(8'(8'h10 + i));
         xfer(1'b0, 8'(8'h10 + i), 0);
         if (i == 15) check("t4_not_full_15", 32'(full), 32'd0);
         if (i == 16) check("t4_full", 32'(full), 32'd1);
      end
      check("t4_full_after_drop", 32'(full), 32'd1);
      n = 0;
      while (full && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t4_full_clears", 32'(full), 32'd0);
      n = 0;
      while (tx_exp.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t4_all_sent", 32'(tx_exp.size()), 32'd0);
      repeat (DIV) @(negedge clk);

      // framing error then good frame
      send_frame(8'h99, 1'b0);
      repeat (2 * DIV) @(negedge clk);
      check("t5_bad_stop_empty", 32'(empty), 32'd1);
      send_frame(8'h99, 1'b1);
      repeat (2 * DIV) @(negedge clk);
      check("t5_good_not_empty", 32'(empty), 32'd0);
      rd_exp.push_back(8'h99); xfer(1'b1, 8'h00, 0);
      check("t5_empty_after_read", 32'(empty), 32'd1);

      // reset mid-frame, then a clean frame
      loop_en = 1'b1;
      xfer(1'b0, 8'h3C, 0);
      repeat (30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6_tx", 32'(tx), 32'd1);
      check("t6_full", 32'(full), 32'd0);
      check("t6_empty", 32'(empty), 32'd1);
      check("t6_ack", 32'(ack), 32'd0);
      check("t6_data_out", 32'(data_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      tx_exp.push_back(8'hC3); xfer(1'b0, 8'hC3, 0);
      n = 0;
      while (empty && n < 150) begin
         @(negedge clk);
         n++;
      end
      check("t6_rx_after_reset", 32'(empty), 32'd0);
      rd_exp.push_back(8'hC3); xfer(1'b1, 8'h00, 0);
      n = 0;
      while (tx_exp.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("tx_exp_left", 32'(tx_exp.size()), 32'd0);
      check("rd_exp_left", 32'(rd_exp.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
